// File: rtl/fpnew_divsqrt_arbiter.sv
// rtl/fpnew_divsqrt_arbiter.sv - round-robin sharing of one in-order div/sqrt unit among requesters
// Responses are steered back through an ID FIFO that remembers the owner of each accepted operation.

package fpnew_pkg;
  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    FP32, FP64, FP16, FP8, FP16ALT
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011,
    RMM = 3'b100, DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
endpackage

module fpnew_divsqrt_arbiter #(
  parameter int NumReq         = 4,
  parameter int Width          = 64,
  parameter int MaxOutstanding = 2,
  localparam int IdxWidth      = $clog2(NumReq)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0][1:0][Width-1:0]     req_operands_i,
  input  fpnew_pkg::operation_e [NumReq-1:0]    req_op_i,
  input  fpnew_pkg::fp_format_e [NumReq-1:0]    req_fmt_i,
  input  fpnew_pkg::roundmode_e [NumReq-1:0]    req_rnd_i,
  input  logic [NumReq-1:0]                     req_valid_i,
  output logic [NumReq-1:0]                     req_ready_o,
  output logic [1:0][Width-1:0]                 unit_operands_o,
  output fpnew_pkg::operation_e                 unit_op_o,
  output fpnew_pkg::fp_format_e                 unit_fmt_o,
  output fpnew_pkg::roundmode_e                 unit_rnd_o,
  output logic                                  unit_in_valid_o,
  input  logic                                  unit_in_ready_i,
  input  logic [Width-1:0]                      unit_result_i,
  input  fpnew_pkg::status_t                    unit_status_i,
  input  logic                                  unit_out_valid_i,
  output logic                                  unit_out_ready_o,
  output logic [Width-1:0]                      rsp_result_o,
  output fpnew_pkg::status_t                    rsp_status_o,
  output logic [NumReq-1:0]                     rsp_valid_o,
  input  logic [NumReq-1:0]                     rsp_ready_i,
  input  logic                                  flush_i,
  output logic                                  flush_o,
  output logic                                  busy_o,
  output logic                                  err_o
);

  localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntWidth = $clog2(MaxOutstanding + 1);

  logic [IdxWidth-1:0] rr_q;
  logic                lock_q;
  logic [IdxWidth-1:0] lock_idx_q;
  logic                err_q;

  logic [IdxWidth-1:0] fifo_q [MaxOutstanding];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] cnt_q;

  logic                fifo_full, fifo_empty;
  logic [IdxWidth-1:0] rr_grant, grant, head, grant_next;
  logic                any_valid, push, pop, orphan;

  assign fifo_full  = (cnt_q == CntWidth'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rd_ptr_q];
  assign any_valid  = |req_valid_i;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int                  cand;
    logic [IdxWidth-1:0] cand_idx;
    logic                found;
    rr_grant = rr_q;
    cand     = 0;
    cand_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      cand     = (int'(rr_q) + i) % NumReq;
      cand_idx = cand[IdxWidth-1:0];
      if (!found && req_valid_i[cand_idx]) begin
        found    = 1'b1;
        rr_grant = cand_idx;
      end
    end
  end

  assign grant      = lock_q ? lock_idx_q : rr_grant;
  assign grant_next = (grant == IdxWidth'(NumReq - 1)) ? '0 : grant + 1'b1;

  assign unit_operands_o = req_operands_i[grant];
  assign unit_op_o       = req_op_i[grant];
  assign unit_fmt_o      = req_fmt_i[grant];
  assign unit_rnd_o      = req_rnd_i[grant];
  assign unit_in_valid_o = any_valid & ~fifo_full & ~flush_i & ~rst_i;

  always_comb begin
    req_ready_o = '0;
    if (unit_in_valid_o && unit_in_ready_i) req_ready_o[grant] = 1'b1;
  end

  // Responses seen during flush or with no recorded owner are swallowed.
  assign unit_out_ready_o = (fifo_empty | flush_i) ? 1'b1 : rsp_ready_i[head];
  assign rsp_result_o     = unit_result_i;
  assign rsp_status_o     = unit_status_i;

  always_comb begin
    rsp_valid_o = '0;
    if (unit_out_valid_i && !fifo_empty && !flush_i && !rst_i) rsp_valid_o[head] = 1'b1;
  end

  assign push   = unit_in_valid_o & unit_in_ready_i;
  assign pop    = unit_out_valid_i & unit_out_ready_o & ~fifo_empty;
  assign orphan = unit_out_valid_i & fifo_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      if (orphan) err_q <= 1'b1;
      if (flush_i) begin
        lock_q   <= 1'b0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q] <= grant;
          wr_ptr_q <= (wr_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
          rr_q     <= grant_next;
          lock_q   <= 1'b0;
        end else if (unit_in_valid_o) begin
          lock_q     <= 1'b1;
          lock_idx_q <= grant;
        end
        if (pop) begin
          rd_ptr_q <= (rd_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign flush_o = flush_i;
  assign busy_o  = ~fifo_empty | any_valid;
  assign err_o   = err_q;

endmodule

// File: tb/tb_fpnew_divsqrt_arbiter.sv
// tb/tb_fpnew_divsqrt_arbiter.sv - directed and randomized checks of fpnew_divsqrt_arbiter
// A queue-based ownership model is compared against the DUT on every falling edge.

module tb_fpnew_divsqrt_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int MO = 2;

  logic                          clk, rst;
  logic [N-1:0][1:0][W-1:0]      req_operands;
  fpnew_pkg::operation_e [N-1:0] req_op;
  fpnew_pkg::fp_format_e [N-1:0] req_fmt;
  fpnew_pkg::roundmode_e [N-1:0] req_rnd;
  logic [N-1:0]                  req_valid, req_ready;
  logic [1:0][W-1:0]             unit_operands;
  fpnew_pkg::operation_e         unit_op;
  fpnew_pkg::fp_format_e         unit_fmt;
  fpnew_pkg::roundmode_e         unit_rnd;
  logic                          unit_in_valid, unit_in_ready;
  logic [W-1:0]                  unit_result, rsp_result;
  fpnew_pkg::status_t            unit_status, rsp_status;
  logic                          unit_out_valid, unit_out_ready;
  logic [N-1:0]                  rsp_valid, rsp_ready;
  logic                          flush, flush_out, busy, err;

  fpnew_divsqrt_arbiter #(.NumReq(N), .Width(W), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_operands_i(req_operands), .req_op_i(req_op), .req_fmt_i(req_fmt), .req_rnd_i(req_rnd),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .unit_operands_o(unit_operands), .unit_op_o(unit_op), .unit_fmt_o(unit_fmt), .unit_rnd_o(unit_rnd),
    .unit_in_valid_o(unit_in_valid), .unit_in_ready_i(unit_in_ready),
    .unit_result_i(unit_result), .unit_status_i(unit_status),
    .unit_out_valid_i(unit_out_valid), .unit_out_ready_o(unit_out_ready),
    .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .flush_i(flush), .flush_o(flush_out), .busy_o(busy), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Model state: owners of in-flight ops, rr pointer, grant lock, sticky error.
  int mq[$];
  int m_rr;
  bit m_lock;
  int m_lock_idx;
  bit m_err;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_valid", 64'(unit_in_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      mq.delete();
      m_rr = 0; m_lock = 0; m_lock_idx = 0; m_err = 0;
    end else begin
      int g;
      bit full, any_v, e_in_valid, e_out_ready, accept, popped;
      logic [N-1:0] e_ready, e_rsp;
      any_v = |req_valid;
      full  = (mq.size() >= MO);
      g = 0;
      if (m_lock) g = m_lock_idx;
      else begin
        for (int k = N - 1; k >= 0; k--)
          if (req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
      e_in_valid  = any_v && !full && !flush;
      e_ready     = (e_in_valid && unit_in_ready) ? N'(1 << g) : '0;
      e_rsp       = (unit_out_valid && mq.size() > 0 && !flush) ? N'(1 << mq[0]) : '0;
      e_out_ready = (mq.size() == 0 || flush) ? 1'b1 : rsp_ready[mq[0]];
      chk("in_valid", 64'(unit_in_valid), 64'(e_in_valid));
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      chk("out_ready", 64'(unit_out_ready), 64'(e_out_ready));
      chk("flush_o", 64'(flush_out), 64'(flush));
      chk("busy", 64'(busy), 64'(mq.size() > 0 || any_v));
      chk("err", 64'(err), 64'(m_err));
      if (e_in_valid) begin
        chk("pay_a", unit_operands[0], req_operands[g][0]);
        chk("pay_b", unit_operands[1], req_operands[g][1]);
        chk("pay_ctl", 64'({unit_op, unit_fmt, unit_rnd}), 64'({req_op[g], req_fmt[g], req_rnd[g]}));
      end
      if (unit_out_valid) begin
        chk("rsp_result", rsp_result, unit_result);
        chk("rsp_status", 64'(rsp_status), 64'(unit_status));
      end
      if (unit_out_valid && mq.size() == 0) m_err = 1;
      if (flush) begin
        mq.delete();
        m_lock = 0;
      end else begin
        accept = e_in_valid && unit_in_ready;
        popped = unit_out_valid && e_out_ready && mq.size() > 0;
        if (popped) void'(mq.pop_front());
        if (accept) begin
          mq.push_back(g);
          m_rr   = (g + 1) % N;
          m_lock = 0;
        end else if (e_in_valid) begin
          m_lock     = 1;
          m_lock_idx = g;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    for (int c = 0; c < 2 * MO + 2; c++) begin
      unit_out_valid = (mq.size() > 0);
      tick();
    end
    unit_out_valid = 1'b0;
  endtask

  task automatic new_req(input int i);
    req_operands[i][0] = {$urandom, $urandom};
    req_operands[i][1] = {$urandom, $urandom};
    req_op[i]  = ($urandom % 2) ? fpnew_pkg::DIV : fpnew_pkg::SQRT;
    req_fmt[i] = ($urandom % 2) ? fpnew_pkg::FP64 : fpnew_pkg::FP32;
    req_rnd[i] = ($urandom % 2) ? fpnew_pkg::RNE : fpnew_pkg::RTZ;
  endtask

  logic [N-1:0] acc;

  initial begin
    rst = 1'b1; flush = 1'b0;
    req_valid = '0; rsp_ready = '1;
    unit_in_ready = 1'b0; unit_out_valid = 1'b0;
    unit_result = '0; unit_status = '0;
    for (int i = 0; i < N; i++) new_req(i);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester: 6.0 / 3.0 on FP64 from requester 2.
    req_operands[2][0] = 64'h4018000000000000;
    req_operands[2][1] = 64'h4008000000000000;
    req_op[2] = fpnew_pkg::DIV; req_fmt[2] = fpnew_pkg::FP64; req_rnd[2] = fpnew_pkg::RNE;
    req_valid = 4'b0100; unit_in_ready = 1'b1;
    @(negedge clk);
    chk("t1_req_ready", 64'(req_ready), 64'h4);
    chk("t1_opa", unit_operands[0], 64'h4018000000000000);
    chk("t1_op", 64'(unit_op), 64'(fpnew_pkg::DIV));
    tick();
    req_valid = '0; unit_out_valid = 1'b1; unit_result = 64'h4000000000000000;
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("t1_result", rsp_result, 64'h4000000000000000);
    tick();
    unit_out_valid = 1'b0;

    // Fairness with all requesters valid and immediate responses.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      unit_out_valid = (mq.size() > 0);
      @(negedge clk);
      chk("fair_grant", 64'(req_ready), 64'(1 << (k % 4)));
      tick();
    end
    drain();

    // Stall lock: requester 1 held while requester 0 appears.
    do_reset();
    req_operands[0][0] = 64'h00000000000000aa;
    req_operands[1][0] = 64'h1111111111111111;
    req_valid = 4'b0010; unit_in_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) req_valid[0] = 1'b1;
      @(negedge clk);
      chk("lock_opa", unit_operands[0], 64'h1111111111111111);
      chk("lock_ready", 64'(req_ready), 64'd0);
      tick();
    end
    unit_in_ready = 1'b1;
    @(negedge clk);
    chk("lock_release", 64'(req_ready), 64'h2);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("lock_next", 64'(req_ready), 64'h1);
    tick();
    drain();

    // Full FIFO blocks a third request until a pop.
    do_reset();
    unit_in_ready = 1'b1;
    req_valid = 4'b0001; tick();
    req_valid = 4'b0010; tick();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("full_in_valid", 64'(unit_in_valid), 64'd0);
    tick();
    unit_out_valid = 1'b1;
    @(negedge clk);
    chk("full_pop_in_valid", 64'(unit_in_valid), 64'd0);
    chk("full_pop_rsp", 64'(rsp_valid), 64'h1);
    tick();
    unit_out_valid = 1'b0;
    @(negedge clk);
    chk("full_after_pop", 64'(req_ready), 64'h4);
    tick();
    drain();

    // Response back-pressure keeps order 3 then 0.
    do_reset();
    req_valid = 4'b1000; tick();
    req_valid = 4'b0001; tick();
    req_valid = '0; unit_out_valid = 1'b1; rsp_ready = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_out_ready", 64'(unit_out_ready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'h8);
      tick();
    end
    rsp_ready = 4'b1111;
    @(negedge clk);
    chk("bp_first", 64'(rsp_valid), 64'h8);
    tick();
    @(negedge clk);
    chk("bp_second", 64'(rsp_valid), 64'h1);
    tick();
    unit_out_valid = 1'b0;

    // Flush with two in flight, then an orphan response.
    do_reset();
    req_valid = 4'b0001; tick();
    req_valid = 4'b0010; tick();
    req_valid = '0; flush = 1'b1; unit_out_valid = 1'b1;
    @(negedge clk);
    chk("flush_o_high", 64'(flush_out), 64'd1);
    chk("flush_no_route", 64'(rsp_valid), 64'd0);
    tick();
    flush = 1'b0; unit_out_valid = 1'b0;
    @(negedge clk);
    chk("flush_empty", 64'(busy), 64'd0);
    chk("flush_err_clear", 64'(err), 64'd0);
    tick();
    unit_out_valid = 1'b1;
    tick();
    unit_out_valid = 1'b0;
    @(negedge clk);
    chk("orphan_err", 64'(err), 64'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("orphan_sticky", 64'(err), 64'd1);
    tick();

    // Randomized traffic honouring the hold-until-accepted rule.
    do_reset();
    acc = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && acc[i]) begin
          req_valid[i] = ($urandom % 2 == 0);
          new_req(i);
        end else if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          new_req(i);
        end
      end
      unit_in_ready  = ($urandom % 4 != 0);
      unit_out_valid = (mq.size() > 0) && ($urandom % 2 == 0);
      unit_result    = {$urandom, $urandom};
      unit_status    = fpnew_pkg::status_t'(5'($urandom));
      rsp_ready      = N'($urandom);
      flush          = ($urandom % 60 == 0);
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
    end
    req_valid = '0; flush = 1'b0; unit_out_valid = 1'b0;

    do_reset();
    @(negedge clk);
    chk("final_err_reset", 64'(err), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
